wb_slave_regfile: RTL and testbench

Synthesizable Wishbone classic single-cycle slave with a bank of byte-addressable 32-bit registers and a programmable number of wait states. It is the responder for the bench Wishbone master: it accepts single and back-to-back reads and writes, returns ACK, ERR or optionally RTY, and echoes the data tag. It is the device under test for master BFM tasks, and the register front end for GPIO-style peripherals.

---
 rtl/wb_slave_regfile.sv | 160 ++++++++++++++++
 tb/tb_wb_slave_regfile.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone classic slave fronting a bank of NREGS
// byte-addressable 32-bit registers, with WAIT_CYCLES wait states before
// a single-cycle registered response (ACK, ERR or RTY).
//
// Optional feature: define WB_SLAVE_RTY_EN to let lock_i turn valid
// accesses into RTY terminations (writes discarded). Without it lock_i is
// ignored and RTY_O stays 0.
//
// Ports:
//   CLK_I           clock, rising edge
//   RST_I           synchronous reset, active-low
//   CYC_I, STB_I    bus cycle / strobe; request sampled when both high in IDLE
//   WE_I            1 = write, 0 = read
//   ADR_I           byte address
//   SEL_I           byte enables
//   DAT_I           write data
//   TAG_I           data tag, echoed on TAG_O with the response
//   lock_i          register bank locked (WB_SLAVE_RTY_EN only)
//   DAT_O           read data while ACK_O, else 0
//   TAG_O           captured tag while any response is high, else 0
//   ACK_O/ERR_O/RTY_O  single-cycle termination strobes
//   regs_o          flat register contents, reg k at [32k+31:32k]
module wb_slave_regfile #(
  parameter int ADR_W       = 32,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int NREGS       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [ADR_W-1:0]        ADR_I,
  input  logic [3:0]              SEL_I,
  input  logic [DATA_W-1:0]       DAT_I,
  input  logic [TAG_W-1:0]        TAG_I,
  input  logic                    lock_i,
  output logic [DATA_W-1:0]       DAT_O,
  output logic [TAG_W-1:0]        TAG_O,
  output logic                    ACK_O,
  output logic                    ERR_O,
  output logic                    RTY_O,
  output logic [NREGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W = $clog2(NREGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADR_W-1:0]  adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] dat_q;
  logic [TAG_W-1:0]  tag_q;
  logic              lock_q;
  logic [DATA_W-1:0] regs [NREGS];

  // lock as seen by the FSM; forced low when retry support is compiled out
  logic lock_now;
`ifdef WB_SLAVE_RTY_EN
  assign lock_now = lock_i;
`else
  logic lock_unused;
  assign lock_unused = lock_i;
  assign lock_now    = 1'b0;
`endif

  logic             adr_err;
  logic             do_retry;
  logic [IDX_W-1:0] idx;

  // Full-width range compare so high address bits never alias into the bank
  assign adr_err  = (adr_q[1:0] != 2'b00) || (adr_q >= ADR_W'(NREGS * 4));
  assign do_retry = lock_q && !adr_err;
  assign idx      = adr_q[2 +: IDX_W];

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state  <= S_IDLE;
      cnt    <= '0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      tag_q  <= '0;
      lock_q <= 1'b0;
      ACK_O  <= 1'b0;
      ERR_O  <= 1'b0;
      RTY_O  <= 1'b0;
      DAT_O  <= '0;
      TAG_O  <= '0;
      for (int unsigned k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      // Response strobes default low so they never last two cycles
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      RTY_O <= 1'b0;
      DAT_O <= '0;
      TAG_O <= '0;
      case (state)
        S_IDLE: begin
          if (CYC_I && STB_I) begin
            adr_q <= ADR_I;
            we_q  <= WE_I;
            sel_q <= SEL_I;
            dat_q <= DAT_I;
            tag_q <= TAG_I;
            if (WAIT_CYCLES == 0) begin
              lock_q <= lock_now;
              state  <= S_RESP;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!CYC_I) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            lock_q <= lock_now;
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          TAG_O <= tag_q;
          if (adr_err) begin
            ERR_O <= 1'b1;
          end else if (do_retry) begin
            RTY_O <= 1'b1;
          end else begin
            ACK_O <= 1'b1;
            if (we_q) begin
              for (int unsigned b = 0; b < 4; b++)
                if (sel_q[b]) regs[idx][8*b +: 8] <= dat_q[8*b +: 8];
            end else begin
              DAT_O <= regs[idx];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NREGS; k++) regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench for wb_slave_regfile: instance A uses WAIT_CYCLES=2,
// instance B uses WAIT_CYCLES=3 for the abort / mid-wait reset cases.
module tb_wb_slave_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cyc_a = 1'b0, stb_a = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  adr = '0;
  logic [3:0]   sel = '0;
  logic [31:0]  dat = '0;
  logic [3:0]   tag = '0;
  logic         lock = 1'b0;

  logic [31:0]  dat_a, dat_b;
  logic [3:0]   tag_a, tag_b;
  logic         ack_a, err_a, rty_a, ack_b, err_b, rty_b;
  logic [255:0] regs_a, regs_b;
  logic [255:0] exp_regs;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_ACK  = 3'b001;
  localparam logic [2:0] R_RTY  = 3'b010;
  localparam logic [2:0] R_ERR  = 3'b100;

  always #5 clk = ~clk;

  wb_slave_regfile #(.ADR_W(32), .DATA_W(32), .TAG_W(4), .NREGS(8), .WAIT_CYCLES(2)) u_dut_a (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_a), .STB_I(stb_a), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .lock_i(lock), .DAT_O(dat_a), .TAG_O(tag_a),
    .ACK_O(ack_a), .ERR_O(err_a), .RTY_O(rty_a), .regs_o(regs_a)
  );

  wb_slave_regfile #(.ADR_W(32), .DATA_W(32), .TAG_W(4), .NREGS(8), .WAIT_CYCLES(3)) u_dut_b (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_b), .STB_I(stb_b), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(dat), .TAG_I(tag), .lock_i(lock), .DAT_O(dat_b), .TAG_O(tag_b),
    .ACK_O(ack_b), .ERR_O(err_b), .RTY_O(rty_b), .regs_o(regs_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
  endtask

  function automatic logic [2:0] resp(input bit b);
    return b ? {err_b, rty_b, ack_b} : {err_a, rty_a, ack_a};
  endfunction

  // One request; response must appear exactly WAIT+1 edges after sampling
  task automatic txn(input bit b, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [3:0] t, input logic [2:0] exp_r,
                     input logic [31:0] exp_d, input string name);
    int unsigned nwait;
    nwait = b ? 3 : 2;
    we = w; adr = a; sel = s; dat = d; tag = t;
    if (b) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else   begin cyc_a = 1'b1; stb_a = 1'b1; end
    tick;
    stb_a = 1'b0; stb_b = 1'b0;
    adr = 32'hFFFF_FFF3; dat = 32'h5A5A_5A5A; sel = 4'hF; // later changes must not matter
    for (int i = 0; i < int'(nwait); i++) begin
      tick;
      chk({name, "_early"}, 256'(resp(b)), 256'(R_NONE));
    end
    tick;
    chk({name, "_resp"}, 256'(resp(b)), 256'(exp_r));
    chk({name, "_dat"}, 256'(b ? dat_b : dat_a), 256'(exp_d));
    chk({name, "_tag"}, 256'(b ? tag_b : tag_a), 256'(t));
    tick;
    cyc_a = 1'b0; cyc_b = 1'b0;
    chk({name, "_pulse"}, 256'({resp(b), (b ? dat_b : dat_a), (b ? tag_b : tag_a)}), 256'(0));
  endtask

  initial begin
    // Reset held for two edges with STB high
    stb_a = 1'b1; stb_b = 1'b1;
    tick; tick;
    chk("rst_out_a", 256'({dat_a, tag_a, ack_a, err_a, rty_a}), 256'(0));
    chk("rst_regs_a", regs_a, 256'(0));
    chk("rst_out_b", 256'({dat_b, tag_b, ack_b, err_b, rty_b}), 256'(0));
    rst = 1'b1; stb_a = 1'b0; stb_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_idle", 256'({resp(0), resp(1)}), 256'(0));
    end

    exp_regs = '0;
    txn(0, 1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 4'h5, R_ACK, 32'h0, "wr4");
    exp_regs[63:32] = 32'hDEADBEEF;
    chk("wr4_regs", regs_a, exp_regs);
    txn(0, 1'b0, 32'h04, 4'h1, 32'h0, 4'h3, R_ACK, 32'hDEADBEEF, "rd4");

    txn(0, 1'b1, 32'h08, 4'hF, 32'hFFFFFFFF, 4'h7, R_ACK, 32'h0, "wr8_ff");
    txn(0, 1'b1, 32'h08, 4'h5, 32'h11223344, 4'h8, R_ACK, 32'h0, "wr8_sel5");
    txn(0, 1'b0, 32'h08, 4'h0, 32'h0, 4'h2, R_ACK, 32'hFF22FF44, "rd8");
    exp_regs[95:64] = 32'hFF22FF44;

    txn(0, 1'b1, 32'h20, 4'hF, 32'h12345678, 4'h9, R_ERR, 32'h0, "err_hi");
    txn(0, 1'b0, 32'h06, 4'hF, 32'h0, 4'hA, R_ERR, 32'h0, "err_mis");
    txn(0, 1'b1, 32'h8000_0004, 4'hF, 32'h0BAD0BAD, 4'hB, R_ERR, 32'h0, "err_alias");
    chk("err_regs", regs_a, exp_regs);

    txn(0, 1'b1, 32'h04, 4'h0, 32'h0BADF00D, 4'h1, R_ACK, 32'h0, "sel0");
    chk("sel0_regs", regs_a, exp_regs);

    // STB without CYC is ignored
    we = 1'b1; adr = 32'h0; dat = 32'hCAFE0000; sel = 4'hF; stb_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stb_nocyc", 256'(resp(0)), 256'(R_NONE));
    end
    stb_a = 1'b0;
    chk("stb_nocyc_regs", regs_a, exp_regs);

`ifdef WB_SLAVE_RTY_EN
    lock = 1'b1;
    txn(0, 1'b1, 32'h0C, 4'hF, 32'hA5, 4'h6, R_RTY, 32'h0, "rty_lock");
    chk("rty_regs", regs_a, exp_regs);
    lock = 1'b0;
    txn(0, 1'b1, 32'h0C, 4'hF, 32'hA5, 4'h6, R_ACK, 32'h0, "rty_retry");
`else
    lock = 1'b1;
    txn(0, 1'b1, 32'h0C, 4'hF, 32'hA5, 4'h6, R_ACK, 32'h0, "lock_ignored");
    lock = 1'b0;
`endif
    exp_regs[127:96] = 32'h000000A5;
    chk("reg3", regs_a, exp_regs);

    // Abort on B: CYC dropped during WAIT
    txn(1, 1'b1, 32'h0, 4'hF, 32'h55, 4'h2, R_ACK, 32'h0, "b_wr0");
    we = 1'b1; adr = 32'h0; dat = 32'h1; sel = 4'hF; tag = 4'h4;
    cyc_b = 1'b1; stb_b = 1'b1;
    tick;
    stb_b = 1'b0;
    tick;
    cyc_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort_resp", 256'(resp(1)), 256'(R_NONE));
    end
    chk("abort_reg0", 256'(regs_b[31:0]), 256'(32'h55));

    // Reset during WAIT on B
    cyc_b = 1'b1; stb_b = 1'b1;
    tick;
    stb_b = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rstwait_resp", 256'(resp(1)), 256'(R_NONE));
    end
    cyc_b = 1'b0;
    chk("rstwait_regs_b", regs_b, 256'(0));
    chk("rstwait_regs_a", regs_a, 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
